// File: rtl/glyph_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | glyph_pkg : glyph ROM geometry, glyph codes and address helper        |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
package glyph_pkg;

  localparam int NUM_GLYPHS   = 13;
  localparam int GLYPH_ROWS   = 22;
  localparam int GLYPH_CODE_W = 4;
  localparam int GLYPH_ROW_W  = 5;
  localparam int GLYPH_ADDR_W = 11;

  localparam logic [GLYPH_CODE_W-1:0] BLANK      = 4'd0;
  localparam logic [GLYPH_CODE_W-1:0] FROG_UP    = 4'd1;
  localparam logic [GLYPH_CODE_W-1:0] FROG_DOWN  = 4'd2;
  localparam logic [GLYPH_CODE_W-1:0] FROG_RIGHT = 4'd3;
  localparam logic [GLYPH_CODE_W-1:0] FROG_LEFT  = 4'd4;
  localparam logic [GLYPH_CODE_W-1:0] CHAR_0     = 4'd5;
  localparam logic [GLYPH_CODE_W-1:0] CHAR_1     = 4'd6;
  localparam logic [GLYPH_CODE_W-1:0] CHAR_2     = 4'd7;
  localparam logic [GLYPH_CODE_W-1:0] CHAR_3     = 4'd8;
  localparam logic [GLYPH_CODE_W-1:0] CHAR_4     = 4'd9;
  localparam logic [GLYPH_CODE_W-1:0] CHAR_5     = 4'd10;
  localparam logic [GLYPH_CODE_W-1:0] CHAR_6     = 4'd11;
  localparam logic [GLYPH_CODE_W-1:0] SOLID      = 4'd12;

  // code*22 + row built from shifts: 22 = 16 + 4 + 2
  function automatic logic [GLYPH_ADDR_W-1:0] glyph_addr(
    input logic [GLYPH_CODE_W-1:0] code,
    input logic [GLYPH_ROW_W-1:0]  row
  );
    logic [GLYPH_ADDR_W-1:0] c;
    c = GLYPH_ADDR_W'(code);
    return (c << 4) + (c << 2) + (c << 1) + GLYPH_ADDR_W'(row);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : round-robin one-hot grant with rotating priority pointer |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;
  logic [PTR_W-1:0] cand;
  logic             found;

  // Search starts at the pointer; the winner's successor becomes the new head.
  always_comb begin
    gnt      = '0;
    rr_ptr_d = rr_ptr_q;
    cand     = '0;
    found    = 1'b0;
    if (!Reset) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        cand = PTR_W'((int'(rr_ptr_q) + off) % NUM_REQ);
        if (!found && req[cand]) begin
          found     = 1'b1;
          gnt[cand] = 1'b1;
          rr_ptr_d  = PTR_W'((int'(cand) + 1) % NUM_REQ);
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/glyph_rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | glyph_rom_arbiter : shares one glyph ROM among renderers, fixed       |
// |                     two-cycle grant-to-response latency               |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module glyph_rom_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_GLYPHS = 13,
  parameter int GLYPH_ROWS = 22,
  parameter int CODE_W     = 4,
  parameter int ROW_W      = 5,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 24
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*CODE_W-1:0] req_code,
  input  logic [NUM_REQ*ROW_W-1:0]  req_row,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err
);

  import glyph_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [CODE_W-1:0] sel_code;
  logic [ROW_W-1:0]  sel_row;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_err;
  logic [ADDR_W-1:0] sel_addr;

  logic              s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]  s1_idx_q,   s1_idx_d;
  logic              s1_err_q,   s1_err_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q,  rsp_data_d;
  logic               rsp_err_q,   rsp_err_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .Clk   (Clk),
    .Reset (Reset),
    .req   (req),
    .gnt   (gnt)
  );

  // gnt is one-hot, so the winner's fields can be picked with a plain scan.
  always_comb begin
    sel_code = '0;
    sel_row  = '0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_code = req_code[i*CODE_W +: CODE_W];
        sel_row  = req_row[i*ROW_W +: ROW_W];
        sel_idx  = IDX_W'(i);
      end
    end
    sel_err  = (int'(sel_code) >= NUM_GLYPHS) || (int'(sel_row) >= GLYPH_ROWS);
    sel_addr = sel_err ? '0
                       : ADDR_W'(glyph_addr(GLYPH_CODE_W'(sel_code), GLYPH_ROW_W'(sel_row)));
  end

  always_comb begin
    s1_valid_d = |gnt;
    s1_idx_d   = s1_idx_q;
    s1_err_d   = s1_err_q;
    rom_addr_d = rom_addr_q;
    if (|gnt) begin
      s1_idx_d   = sel_idx;
      s1_err_d   = sel_err;
      rom_addr_d = sel_addr;
    end
  end

  // Out-of-range accesses still read ROM address 0; their data is forced to zero here.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (s1_valid_q) begin
      rsp_valid_d[s1_idx_q] = 1'b1;
      rsp_data_d            = s1_err_q ? '0 : rom_data;
      rsp_err_d             = s1_err_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      s1_err_q    <= 1'b0;
      rom_addr_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_idx_q    <= s1_idx_d;
      s1_err_q    <= s1_err_d;
      rom_addr_q  <= rom_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire
